// File: rtl/aes_stream_ctrl.sv
// aes_stream_ctrl: multi-channel round-robin front-end for a fixed-latency AES-256 core; stats counters built only with AES_STREAM_STATS_EN
module aes_stream_ctrl #(
  parameter int NCH      = 4,
  parameter int CORE_LAT = 14,
  parameter int DEPTH    = 8,
  parameter int CH_W     = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NCH-1:0]       in_valid,
  output logic [NCH-1:0]       in_ready,
  input  logic [NCH*128-1:0]   in_data,
  input  logic [NCH-1:0]       in_mode,
  input  logic                 key_wr,
  input  logic [CH_W-1:0]      key_wr_idx,
  input  logic [255:0]         key_wr_data,
  input  logic                 seed_wr,
  input  logic [255:0]         seed_data,
  output logic                 seed_busy,
  output logic [255:0]         core_key,
  output logic [127:0]         core_data,
  output logic [255:0]         core_seed,
  input  logic [127:0]         core_enc_out,
  input  logic [127:0]         core_dec_out,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [127:0]         out_data,
  output logic [CH_W-1:0]      out_ch,
  output logic                 out_mode,
  output logic [31:0]          stat_issued,
  output logic [31:0]          stat_stall
);
  localparam int AW = $clog2(DEPTH);
  localparam int FW = 128 + CH_W + 1;

  logic [255:0]    key_q [2**CH_W];
  logic [255:0]    seed_q, core_key_q;
  logic [127:0]    core_data_q;
  logic [CH_W-1:0] ptr_q, ptr_d, gnt;
  logic            found, issue, push, pop;
  // Stage 0 travels alongside core_data; stage CORE_LAT lines up with the core result.
  logic [CORE_LAT:0] tv_q, tm_q;
  logic [CH_W-1:0]   tch_q [CORE_LAT+1];
  logic [FW-1:0]     mem [DEPTH];
  logic [AW-1:0]     wr_q, rd_q;
  logic [AW:0]       cnt_q;

  // Round-robin pick: scan downward so the nearest valid channel after ptr_q wins.
  always_comb begin
    gnt = '0;
    found = 1'b0;
    for (int k = NCH - 1; k >= 0; k--) begin
      if (in_valid[(32'(ptr_q) + k) % NCH]) begin
        gnt = CH_W'((32'(ptr_q) + k) % NCH);
        found = 1'b1;
      end
    end
  end

  // In-flight tags count against FIFO space so a result can never find the FIFO full.
  assign issue     = rst & found & ~seed_wr & (32'(cnt_q) + $countones(tv_q) < DEPTH);
  assign in_ready  = issue ? (NCH'(1) << gnt) : '0;
  assign ptr_d     = (32'(gnt) == NCH - 1) ? '0 : gnt + 1'b1;
  assign seed_busy = (|tv_q) | (cnt_q != '0);
  assign core_key  = core_key_q;
  assign core_data = core_data_q;
  assign core_seed = seed_q;

  // Key/seed registers, issue registers and the tag pipeline.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 2**CH_W; i++) key_q[i] <= '0;
      for (int i = 0; i <= CORE_LAT; i++) tch_q[i] <= '0;
      seed_q      <= '0;
      core_key_q  <= '0;
      core_data_q <= '0;
      ptr_q       <= '0;
      tv_q        <= '0;
      tm_q        <= '0;
    end else begin
      if (key_wr) key_q[key_wr_idx] <= key_wr_data;
      if (seed_wr && !seed_busy) seed_q <= seed_data;
      tv_q     <= {tv_q[CORE_LAT-1:0], issue};
      tm_q     <= {tm_q[CORE_LAT-1:0], in_mode[gnt]};
      tch_q[0] <= gnt;
      for (int i = 1; i <= CORE_LAT; i++) tch_q[i] <= tch_q[i-1];
      if (issue) begin
        core_data_q <= in_data[128*gnt +: 128];
        core_key_q  <= key_q[gnt];
        ptr_q       <= ptr_d;
      end
    end
  end

  assign push      = tv_q[CORE_LAT];
  assign out_valid = cnt_q != '0;
  assign pop       = out_valid & out_ready;
  assign {out_mode, out_ch, out_data} = out_valid ? mem[rd_q] : '0;

  // Result storage; the mode bit of the tag selects which core output is kept.
  always_ff @(posedge clk) begin
    if (push) mem[wr_q] <= {tm_q[CORE_LAT], tch_q[CORE_LAT], tm_q[CORE_LAT] ? core_dec_out : core_enc_out};
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_q + AW'(push);
      rd_q  <= rd_q + AW'(pop);
      cnt_q <= cnt_q + (AW+1)'(push) - (AW+1)'(pop);
    end
  end

`ifdef AES_STREAM_STATS_EN
  logic [31:0] iss_q, stl_q;
  // Saturating issue and backpressure-stall counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      iss_q <= '0;
      stl_q <= '0;
    end else begin
      if (issue && !(&iss_q)) iss_q <= iss_q + 32'd1;
      if (out_valid && !out_ready && !(&stl_q)) stl_q <= stl_q + 32'd1;
    end
  end
  assign stat_issued = iss_q;
  assign stat_stall  = stl_q;
`else
  assign stat_issued = '0;
  assign stat_stall  = '0;
`endif
endmodule
